// File: rtl/itype_stim_sequencer.sv
// Request-driven instruction-memory responder: warm-up NOPs, LFSR-generated
// I-type ALU instructions, then drain NOPs, answering each fetch one cycle later.
module itype_stim_sequencer #(
   parameter int unsigned NUM_INSTR = 64,
   parameter int unsigned WARMUP    = 4,
   parameter int unsigned DRAIN     = 5,
   parameter logic [31:0] SEED      = 32'h00000289
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        imem_req_valid,
   output logic        imem_resp_valid,
   output logic [31:0] imem_resp_data,
   output logic        busy,
   output logic        done,
   output logic [15:0] issued_count
);

   localparam logic [31:0] NOP       = 32'h00000013;
   localparam logic [31:0] TAPS      = 32'h80200003;
   localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [31:0] WARM_LAST = WARMUP - 1;
   localparam logic [31:0] RUN_LAST  = NUM_INSTR - 1;
   localparam logic [31:0] DRN_LAST  = DRAIN - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WARM,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] phase_q, phase_d;
   logic [31:0] lfsr_q, lfsr_d;
   logic [15:0] count_q, count_d;
   logic        resp_valid_p1, resp_valid_p0;
   logic [31:0] resp_data_p1, resp_data_p0;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      logic [31:0] n;
      n = v >> 1;
      if (v[0]) n = n ^ TAPS;
      return n;
   endfunction

   // Shift immediates must stay legal: shamt only, plus the SRAI selector bit.
   function automatic logic [31:0] itype_word(input logic [31:7] v);
      logic [11:0] imm;
      logic [2:0]  f3;
      imm = v[31:20];
      f3  = v[14:12];
      if (f3 == 3'd5)      imm = imm & 12'h41F;
      else if (f3 == 3'd1) imm = imm & 12'h01F;
      return {imm, v[19:15], f3, v[11:7], 7'b0010011};
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      lfsr_d        = lfsr_q;
      count_d       = count_q;
      resp_valid_p0 = imem_req_valid;
      resp_data_p0  = imem_req_valid ? NOP : resp_data_p1;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               count_d = 16'd0;
               phase_d = 32'd0;
               state_d = (WARMUP == 0) ? S_RUN : S_WARM;
            end
         end
         S_WARM: begin
            if (imem_req_valid) begin
               if (phase_q == WARM_LAST) begin
                  phase_d = 32'd0;
                  state_d = S_RUN;
               end else begin
                  phase_d = phase_q + 32'd1;
               end
            end
         end
         S_RUN: begin
            if (imem_req_valid) begin
               resp_data_p0 = itype_word(lfsr_q[31:7]);
               lfsr_d       = lfsr_step(lfsr_q);
               count_d      = sat_inc16(count_q);
               if (phase_q == RUN_LAST) begin
                  phase_d = 32'd0;
                  state_d = (DRAIN == 0) ? S_DONE : S_DRAIN;
               end else begin
                  phase_d = phase_q + 32'd1;
               end
            end
         end
         S_DRAIN: begin
            if (imem_req_valid) begin
               if (phase_q == DRN_LAST) begin
                  phase_d = 32'd0;
                  state_d = S_DONE;
               end else begin
                  phase_d = phase_q + 32'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // p0 -> p1: response registered one cycle after the accepted request
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         phase_q       <= 32'd0;
         lfsr_q        <= SEED_EFF;
         count_q       <= 16'd0;
         resp_valid_p1 <= 1'b0;
         resp_data_p1  <= NOP;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         lfsr_q        <= lfsr_d;
         count_q       <= count_d;
         resp_valid_p1 <= resp_valid_p0;
         resp_data_p1  <= resp_data_p0;
      end
   end

   assign imem_resp_valid = resp_valid_p1;
   assign imem_resp_data  = resp_data_p1;
   assign busy            = (state_q == S_WARM) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done            = (state_q == S_DONE);
   assign issued_count    = count_q;

endmodule

// File: tb/tb_itype_stim_sequencer.sv
// Directed bench for itype_stim_sequencer: reset/warm-up vector table, then
// hand-written run, stall, restart and mid-run reset sequences against a golden LFSR.
module tb_itype_stim_sequencer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, start, req;
   logic        rv, busy, done;
   logic [31:0] rd;
   logic [15:0] cnt;

   logic        s_rst_n, s_start, s_req;
   logic        s1_rv, s1_busy, s1_done, s5_rv, s5_busy, s5_done;
   logic [31:0] s1_rd, s5_rd;
   logic [15:0] s1_cnt, s5_cnt;

   itype_stim_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .imem_req_valid(req),
      .imem_resp_valid(rv), .imem_resp_data(rd), .busy(busy), .done(done),
      .issued_count(cnt));

   itype_stim_sequencer #(.NUM_INSTR(1), .WARMUP(0), .DRAIN(0), .SEED(32'hFFF01080)) dut_s1 (
      .clk(clk), .reset_n(s_rst_n), .start(s_start), .imem_req_valid(s_req),
      .imem_resp_valid(s1_rv), .imem_resp_data(s1_rd), .busy(s1_busy), .done(s1_done),
      .issued_count(s1_cnt));

   itype_stim_sequencer #(.NUM_INSTR(1), .WARMUP(0), .DRAIN(0), .SEED(32'hFFF05080)) dut_s5 (
      .clk(clk), .reset_n(s_rst_n), .start(s_start), .imem_req_valid(s_req),
      .imem_resp_valid(s5_rv), .imem_resp_data(s5_rd), .busy(s5_busy), .done(s5_done),
      .issued_count(s5_cnt));

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       nm;
      logic        rn, st, rq;
      logic        ev;
      logic [31:0] ed;
      logic        eb, edn;
      logic [15:0] ec;
   } vec_t;

   vec_t        tbl[10];
   logic [31:0] gold[64];
   logic [31:0] lf;

   function automatic logic [31:0] m_step(input logic [31:0] s);
      logic [31:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 32'h80200003;
      return n;
   endfunction

   function automatic logic [31:0] m_word(input logic [31:0] s);
      logic [11:0] imm;
      imm = s[31:20];
      if (s[14:12] == 3'd5)      imm = imm & 12'h41F;
      else if (s[14:12] == 3'd1) imm = imm & 12'h01F;
      return {imm, s[19:15], s[14:12], s[11:7], 7'h13};
   endfunction

   function automatic logic [50:0] pk(input logic v, input logic [31:0] d, input logic b,
                                      input logic dn, input logic [15:0] c);
      return {v, d, b, dn, c};
   endfunction

   task automatic chk(input string nm, input logic [50:0] act, input logic [50:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got v=%b d=%h busy=%b done=%b cnt=%0d, expected v=%b d=%h busy=%b done=%b cnt=%0d",
                  nm, act[50], act[49:18], act[17], act[16], act[15:0],
                  exp[50], exp[49:18], exp[17], exp[16], exp[15:0]);
      end
   endtask

   task automatic cyc(input logic rn, input logic st, input logic rq);
      @(negedge clk);
      reset_n = rn; start = st; req = rq;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_s(input logic rn, input logic st, input logic rq);
      @(negedge clk);
      s_rst_n = rn; s_start = st; s_req = rq;
      @(posedge clk);
      #1;
   endtask

   // Full pass: warm-up NOPs, 64 words against an expected list, drain, DONE.
   task automatic run_full(input string tag, input logic from_start);
      if (from_start) begin
         cyc(1, 1, 0);
         chk({tag, "_start"}, pk(rv, rd, busy, done, cnt), pk(0, 32'h13, 1, 0, 0));
      end
      for (int k = 0; k < 4; k++) begin
         cyc(1, 0, 1);
         chk({tag, "_warm"}, pk(rv, rd, busy, done, cnt), pk(1, 32'h13, 1, 0, 0));
      end
      for (int i = 0; i < 64; i++) begin
         cyc(1, 0, 1);
         chk({tag, "_word"}, pk(rv, rd, busy, done, cnt), pk(1, gold[i], 1, 0, 16'(i + 1)));
      end
      for (int k = 1; k <= 5; k++) begin
         cyc(1, 0, 1);
         chk({tag, "_drain"}, pk(rv, rd, busy, done, cnt),
             pk(1, 32'h13, (k < 5), (k == 5), 16'd64));
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; req = 1'b1;
      s_rst_n = 1'b0; s_start = 1'b0; s_req = 1'b0;

      tbl[0] = '{"rst0",      0, 0, 1, 0, 32'h13,  0, 0, 16'd0};
      tbl[1] = '{"rst1",      0, 0, 1, 0, 32'h13,  0, 0, 16'd0};
      tbl[2] = '{"rst_start", 0, 1, 1, 0, 32'h13,  0, 0, 16'd0};
      tbl[3] = '{"start",     1, 1, 0, 0, 32'h13,  1, 0, 16'd0};
      tbl[4] = '{"warm1",     1, 0, 1, 1, 32'h13,  1, 0, 16'd0};
      tbl[5] = '{"warm2",     1, 0, 1, 1, 32'h13,  1, 0, 16'd0};
      tbl[6] = '{"warm3",     1, 0, 1, 1, 32'h13,  1, 0, 16'd0};
      tbl[7] = '{"warm4",     1, 0, 1, 1, 32'h13,  1, 0, 16'd0};
      tbl[8] = '{"run_first", 1, 0, 1, 1, 32'h293, 1, 0, 16'd1};
      tbl[9] = '{"idle_hold", 1, 0, 0, 0, 32'h293, 1, 0, 16'd1};

      lf = 32'h00000289;
      for (int i = 0; i < 64; i++) begin
         gold[i] = m_word(lf);
         lf = m_step(lf);
      end

      // Shift-immediate masking on dedicated single-instruction instances.
      cyc_s(0, 0, 1);
      chk("s1_reset", pk(s1_rv, s1_rd, s1_busy, s1_done, s1_cnt), pk(0, 32'h13, 0, 0, 0));
      cyc_s(1, 1, 0);
      chk("s1_to_run", pk(s1_rv, s1_rd, s1_busy, s1_done, s1_cnt), pk(0, 32'h13, 1, 0, 0));
      cyc_s(1, 0, 1);
      chk("slli_mask", pk(s1_rv, s1_rd, s1_busy, s1_done, s1_cnt), pk(1, 32'h01F01093, 0, 1, 1));
      chk("srai_mask", pk(s5_rv, s5_rd, s5_busy, s5_done, s5_cnt), pk(1, 32'h41F05093, 0, 1, 1));
      cyc_s(1, 0, 1);
      chk("s1_done_nop", pk(s1_rv, s1_rd, s1_busy, s1_done, s1_cnt), pk(1, 32'h13, 0, 1, 1));
      chk("s5_done_nop", pk(s5_rv, s5_rd, s5_busy, s5_done, s5_cnt), pk(1, 32'h13, 0, 1, 1));
      cyc_s(1, 0, 0);

      for (int v = 0; v < 10; v++) begin
         cyc(tbl[v].rn, tbl[v].st, tbl[v].rq);
         chk(tbl[v].nm, pk(rv, rd, busy, done, cnt),
             pk(tbl[v].ev, tbl[v].ed, tbl[v].eb, tbl[v].edn, tbl[v].ec));
      end

      // Remaining 63 words with a 3-cycle request gap after word 20.
      for (int i = 1; i < 64; i++) begin
         if (i == 20) begin
            for (int g = 0; g < 3; g++) begin
               cyc(1, 0, 0);
               chk("stall", pk(rv, rd, busy, done, cnt), pk(0, gold[19], 1, 0, 16'd20));
            end
         end
         cyc(1, 0, 1);
         chk("run_word", pk(rv, rd, busy, done, cnt), pk(1, gold[i], 1, 0, 16'(i + 1)));
      end
      for (int k = 1; k <= 5; k++) begin
         cyc(1, 0, 1);
         chk("drain", pk(rv, rd, busy, done, cnt), pk(1, 32'h13, (k < 5), (k == 5), 16'd64));
      end
      cyc(1, 0, 0);
      chk("done_hold", pk(rv, rd, busy, done, cnt), pk(0, 32'h13, 0, 1, 16'd64));

      // Restart from DONE: LFSR continues; start mid-RUN is ignored.
      cyc(1, 1, 0);
      chk("restart", pk(rv, rd, busy, done, cnt), pk(0, 32'h13, 1, 0, 16'd0));
      for (int k = 0; k < 4; k++) begin
         cyc(1, 0, 1);
         chk("rewarm", pk(rv, rd, busy, done, cnt), pk(1, 32'h13, 1, 0, 16'd0));
      end
      for (int j = 0; j < 10; j++) begin
         cyc(1, (j == 5), 1);
         chk((j == 5) ? "start_in_run" : "cont_word", pk(rv, rd, busy, done, cnt),
             pk(1, m_word(lf), 1, 0, 16'(j + 1)));
         lf = m_step(lf);
      end

      // Reset mid-run, idle NOPs, then a full replay from the seed.
      cyc(0, 0, 1);
      chk("midrun_reset", pk(rv, rd, busy, done, cnt), pk(0, 32'h13, 0, 0, 16'd0));
      for (int k = 0; k < 2; k++) begin
         cyc(1, 0, 1);
         chk("idle_nop", pk(rv, rd, busy, done, cnt), pk(1, 32'h13, 0, 0, 16'd0));
      end
      run_full("replay", 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
